// File: rtl/sync_rr_merge5_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_rr_merge5_sched_pkg
// Description : Shared constants, state type and pointer helper for the
//               5-way round-robin packet merge scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_rr_merge5_sched_pkg;

    localparam int N_REQ = 5;
    localparam int SRC_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    function automatic logic [SRC_W-1:0] next_ptr(input logic [SRC_W-1:0] idx);
        if (idx >= SRC_W'(N_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = idx + 1'b1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_rr_merge5_sched_rr_pick5.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick5
// Description : Combinational rotating-priority picker; i_ptr names the
//               highest-priority requester, priority wraps modulo 5.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick5
    import sync_rr_merge5_sched_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SRC_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt_onehot,
    output logic [SRC_W-1:0] o_gnt_idx,
    output logic             o_any
);

    logic [SRC_W:0]   w_sum;
    logic [SRC_W-1:0] w_cand;

    // Walk from lowest to highest priority so the highest-priority hit wins last.
    always_comb begin
        o_gnt_onehot = '0;
        o_gnt_idx    = '0;
        o_any        = 1'b0;
        w_sum        = '0;
        w_cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum  = {1'b0, i_ptr} + (SRC_W+1)'(k);
            w_cand = (w_sum >= (SRC_W+1)'(N_REQ)) ? SRC_W'(w_sum - (SRC_W+1)'(N_REQ))
                                                  : w_sum[SRC_W-1:0];
            if (i_req[w_cand]) begin
                o_gnt_onehot = N_REQ'(1) << w_cand;
                o_gnt_idx    = w_cand;
                o_any        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_rr_merge5_sched.sv
`default_nettype none
// ============================================================================
// Module      : sync_rr_merge5_sched
// Description : 5-source round-robin valid/ready merge with per-packet grant
//               locking, forced release after MAX_BEATS and registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_rr_merge5_sched
    import sync_rr_merge5_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int MAX_BEATS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      i_valid_5,
    input  logic [N_REQ-1:0]      i_last_5,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [DATA_WIDTH-1:0] i_data2,
    input  logic [DATA_WIDTH-1:0] i_data3,
    input  logic [DATA_WIDTH-1:0] i_data4,
    output logic [N_REQ-1:0]      o_ready_5,
    output logic                  o_valid,
    output logic                  o_last,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [SRC_W-1:0]      o_src,
    input  logic                  i_ready,
    output logic                  o_overrun
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SRC_W-1:0]      r_ptr;
    logic [SRC_W-1:0]      r_owner;
    logic [CNT_W-1:0]      r_beat_cnt;

    logic                  r_valid;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_data;
    logic [SRC_W-1:0]      r_src;
    logic                  r_overrun;

    logic                  w_slot_free;
    logic [N_REQ-1:0]      w_gnt_onehot;
    logic [SRC_W-1:0]      w_gnt_idx;
    logic                  w_gnt_any;
    logic [N_REQ-1:0]      w_ready;
    logic [SRC_W-1:0]      w_sel_idx;
    logic                  w_sel_last;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_cnt_limit;
    logic                  w_force;
    logic                  w_release;

    assign w_slot_free = ~r_valid | i_ready;

    rr_pick5 u_pick (
        .i_req        (i_valid_5),
        .i_ptr        (r_ptr),
        .o_gnt_onehot (w_gnt_onehot),
        .o_gnt_idx    (w_gnt_idx),
        .o_any        (w_gnt_any)
    );

    assign w_sel_idx   = (r_state == ST_LOCK) ? r_owner : w_gnt_idx;
    assign w_sel_last  = i_last_5[w_sel_idx];
    assign w_accept    = |(i_valid_5 & w_ready);
    assign w_cnt_inc   = r_beat_cnt + 1'b1;
    assign w_cnt_limit = (w_cnt_inc == CNT_W'(MAX_BEATS));
    assign w_release   = (r_state == ST_LOCK) && w_accept && (w_sel_last || w_cnt_limit);
    // A limit hit without an upstream last is the only way o_last gets synthesised.
    assign w_force     = (r_state == ST_LOCK) && w_accept && !w_sel_last && w_cnt_limit;

    always_comb begin
        w_sel_data = i_data0;
        case (w_sel_idx)
            3'd1:    w_sel_data = i_data1;
            3'd2:    w_sel_data = i_data2;
            3'd3:    w_sel_data = i_data3;
            3'd4:    w_sel_data = i_data4;
            default: w_sel_data = i_data0;
        endcase
    end

    // FSM: state register, pointer, owner and beat counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                if (w_accept) begin
                    r_owner <= w_gnt_idx;
                    if (w_sel_last) begin
                        r_ptr <= next_ptr(w_gnt_idx);
                    end else begin
                        r_beat_cnt <= CNT_W'(1);
                    end
                end
            end else if (w_accept) begin
                if (w_release) begin
                    r_ptr      <= next_ptr(r_owner);
                    r_beat_cnt <= '0;
                end else begin
                    r_beat_cnt <= w_cnt_inc;
                end
            end
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && !w_sel_last) w_state_nxt = ST_LOCK;
            ST_LOCK: if (w_release)               w_state_nxt = ST_IDLE;
            default:                              w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: output logic (upstream accepts)
    always_comb begin
        w_ready = '0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: w_ready = w_gnt_any ? (w_gnt_onehot & {N_REQ{w_slot_free}}) : '0;
                ST_LOCK: w_ready = (N_REQ'(1) << r_owner) & {N_REQ{w_slot_free}};
                default: w_ready = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_data    <= '0;
            r_src     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_force;
            if (w_accept) begin
                r_valid <= 1'b1;
                r_last  <= w_sel_last | w_force;
                r_data  <= w_sel_data;
                r_src   <= w_sel_idx;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_ready_5 = w_ready;
    assign o_valid   = r_valid;
    assign o_last    = r_last;
    assign o_data    = r_data;
    assign o_src     = r_src;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: doc/sync_rr_merge5_sched.md
# sync_rr_merge5_sched

Synchronous 5-requester round-robin merge scheduler with packet locking. It shares one downstream valid/ready channel among five upstream valid/ready sources and holds the grant for a whole packet, delimited by a per-source last flag. It is the clocked counterpart of the asynchronous 5-way arbitrated merge. It sits in front of shared single-consumer resources: output FIFOs, a shared PE port, and NoC injection.

## Interface
Parameters:
- DATA_WIDTH, 12, beat payload width
- MAX_BEATS, 16, maximum beats per packet before forced release (≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid_5  in  5  per-source beat valid
- i_last_5  in  5  per-source end-of-packet flag, qualified by valid
- i_data0..i_data4  in  DATA_WIDTH each  per-source payload
- o_ready_5  out  5  per-source accept, combinational, at most one bit set
- o_valid  out  1  output beat valid (registered)
- o_last  out  1  output end-of-packet (registered)
- o_data  out  DATA_WIDTH  output payload (registered)
- o_src  out  3  index 0..4 of the source of the current output beat
- i_ready  in  1  downstream accept
- o_overrun  out  1  one-cycle pulse when a packet is force-released

## Operation
- Handshakes:
  - Upstream beat k is accepted when i_valid_5[k] & o_ready_5[k].
  - The output beat is consumed when o_valid & i_ready.
- slot_free = ~o_valid | i_ready. The output register loads an accepted beat on the same edge.
- Round-robin pointer ptr (0..4, reset 0): the highest-priority source. Priority runs ptr, ptr+1, …, 4, 0, … (mod 5).
- State IDLE:
  - winner w = first valid source from ptr.
  - o_ready_5 = onehot(w) & slot_free. It is 0 if no source is valid or slot_free = 0.
  - On acceptance with i_last_5[w] = 1: stay in IDLE, ptr ← (w+1) mod 5.
  - On acceptance with i_last_5[w] = 0: go to LOCK, owner ← w, beat_cnt ← 1.
- State LOCK:
  - o_ready_5 = onehot(owner) & slot_free. Other sources are ignored even if valid.
  - Each accepted owner beat increments beat_cnt.
  - When an accepted beat has last = 1, or beat_cnt+1 == MAX_BEATS: go to IDLE, ptr ← (owner+1) mod 5.
  - On a forced release (no last): the emitted o_last = 1 and o_overrun pulses on the edge that loads that beat.
- Output register load: o_data ← i_dataW, o_src ← W, o_last ← last (or forced), o_valid ← 1.
  - If the output is consumed and nothing is accepted: o_valid ← 0.
  - o_data, o_src and o_last are held stable while o_valid & ~i_ready.
- o_valid never depends combinationally on i_ready. o_ready_5 depends on i_valid_5, state, o_valid and i_ready.
- Reset values: o_valid 0, o_last 0, o_data 0, o_src 0, o_overrun 0, ptr 0, state IDLE, beat_cnt 0. o_ready_5 evaluates to 0 while rst is asserted.
- Reset mid-packet drops the lock and clears the output register. The partial packet is lost; sources must re-send.
- beat_cnt width is clog2(MAX_BEATS+1). It counts 1..MAX_BEATS and never wraps.

## Timing
- Latency: 1 cycle from upstream acceptance edge to o_valid.
- Throughput: 1 beat/cycle with i_ready held high, including back-to-back packets from different sources. The IDLE arbitration occurs in the cycle after the last beat, with no bubble.
- Backpressure: i_ready low with o_valid high → o_ready_5 = 0 the same cycle.
- A source asserting valid while another holds LOCK waits at most (owner remaining beats) + 4 × MAX_BEATS beats.
- Single-beat packets (last on the first beat) never enter LOCK.

## Structure
- Shared package:
  - N_REQ = 5, SRC_W = 3.
  - State enum {IDLE, LOCK}.
  - Function next_ptr(idx) = (idx+1) mod N_REQ.
- Sub-module rr_pick5: combinational rotating-priority picker. Inputs: req[4:0], ptr[2:0]. Outputs: gnt_onehot[4:0], gnt_idx[2:0], any.
- Top holds the FSM, pointer, beat counter, output register and the data mux.

## Test plan
- After reset, hold all 5 sources valid with last = 1 and i_ready = 1 → o_src sequence 0,1,2,3,4,0 on consecutive cycles; o_valid stays 1.
- Source 2 sends a 3-beat packet (A,B,C) while source 0 is continuously valid → output 2:A,2:B,2:C(last), then 0:…; o_ready_5[0] = 0 during the lock.
- i_ready = 0 for 4 cycles with o_valid = 1 → o_data and o_src held, o_ready_5 = 0; the next beat appears 1 cycle after i_ready returns high.
- With MAX_BEATS = 16, source 4 streams with last = 0 → the 16th beat emitted has o_last = 1, o_overrun pulses once, and the next grant goes to source 0 if it is valid.
- Assert rst during the 2nd beat of a locked packet from source 1 → o_valid = 0 and ptr = 0 immediately; with sources 0 and 1 valid after release, source 0 is granted first.
- Only source 3 valid, alternating single-beat packets → accepted every cycle, o_src = 3 each time, ptr = 4 after each beat.
